// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, one operand bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_shift;

  assign fa_s  = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_co = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at sum[0].
  generate
    if (WIDTH == 1) begin : g_one
      assign sum_shift = fa_s;
    end else begin : g_multi
      assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        sum_d   = sum_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on this last step
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign sum         = sum_q;
  assign c_out       = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances against an arithmetic model.
// ovf is checked only when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  logic       clk;
  logic       rst;

  logic       s8_sv, s8_sr, s8_cin, s8_cout, s8_dv, s8_dr, s8_busy;
  logic [7:0] s8_a, s8_b, s8_sum;
  logic       s1_sv, s1_sr, s1_cin, s1_cout, s1_dv, s1_dr, s1_busy;
  logic [0:0] s1_a, s1_b, s1_sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic       s8_ovf, s1_ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_valid(s8_sv), .start_ready(s8_sr),
    .a(s8_a), .b(s8_b), .c_in(s8_cin), .sum(s8_sum), .c_out(s8_cout),
    .done_valid(s8_dv), .done_ready(s8_dr), .busy(s8_busy)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(s8_ovf)
`endif
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start_valid(s1_sv), .start_ready(s1_sr),
    .a(s1_a), .b(s1_b), .c_in(s1_cin), .sum(s1_sum), .c_out(s1_cout),
    .done_valid(s1_dv), .done_ready(s1_dr), .busy(s1_busy)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(s1_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned sum/carry and signed overflow from plain integer arithmetic.
  function automatic void model(input int ta, input int tb, input int tc, input int w,
                                output int es, output bit ec, output bit eo);
    int total, sa, sb, r, lim;
    total = ta + tb + tc;
    es    = total % (1 << w);
    ec    = ((total >> w) != 0);
    lim   = 1 << (w - 1);
    sa    = (ta >= lim) ? ta - (1 << w) : ta;
    sb    = (tb >= lim) ? tb - (1 << w) : tb;
    r     = sa + sb + tc;
    eo    = (r > lim - 1) || (r < -lim);
  endfunction

  task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input logic eo, input string tag);
    int k;
    @(negedge clk);
    checks++;
    if (s8_sr !== 1'b1) begin errors++; $display("FAIL %s ready: got %b want 1", tag, s8_sr); end
    s8_a = ta; s8_b = tb; s8_cin = tc; s8_sv = 1'b1;
    @(negedge clk);
    s8_sv = 1'b0;
    s8_a = 8'($urandom_range(0, 255)); s8_b = 8'($urandom_range(0, 255)); s8_cin = 1'($urandom_range(0, 1));
    checks++;
    if (s8_busy !== 1'b1 || s8_dv !== 1'b0) begin
      errors++; $display("FAIL %s run: busy=%b dv=%b want busy=1 dv=0", tag, s8_busy, s8_dv);
    end
    k = 0;
    while (s8_dv !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    checks++;
    if (k != 8) begin errors++; $display("FAIL %s latency: got %0d want 8", tag, k); end
    checks++;
    if (s8_sum !== es || s8_cout !== ec) begin
      errors++; $display("FAIL %s result: got sum=%h cout=%b want sum=%h cout=%b", tag, s8_sum, s8_cout, es, ec);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (s8_ovf !== eo) begin errors++; $display("FAIL %s ovf: got %b want %b", tag, s8_ovf, eo); end
`else
    if (eo === 1'bx) $display("note: %s ovf expectation unknown", tag);
`endif
    s8_dr = 1'b1;
    @(negedge clk);
    s8_dr = 1'b0;
    checks++;
    if (s8_dv !== 1'b0 || s8_sr !== 1'b1 || s8_sum !== es || s8_cout !== ec) begin
      errors++; $display("FAIL %s take: dv=%b ready=%b sum=%h cout=%b want dv=0 ready=1 sum=%h cout=%b",
                         tag, s8_dv, s8_sr, s8_sum, s8_cout, es, ec);
    end
    $display("op8 %s: a=%h b=%h cin=%b -> sum=%h cout=%b", tag, ta, tb, tc, s8_sum, s8_cout);
  endtask

  task automatic do_op1(input logic ta, input logic tb, input logic tc,
                        input logic es, input logic ec, input logic eo, input string tag);
    @(negedge clk);
    s1_a = ta; s1_b = tb; s1_cin = tc; s1_sv = 1'b1;
    @(negedge clk);
    s1_sv = 1'b0;
    s1_a = ~ta; s1_b = ~tb; s1_cin = ~tc;
    checks++;
    if (s1_busy !== 1'b1 || s1_dv !== 1'b0) begin
      errors++; $display("FAIL %s run: busy=%b dv=%b want busy=1 dv=0", tag, s1_busy, s1_dv);
    end
    @(negedge clk);
    checks++;
    if (s1_dv !== 1'b1 || s1_sum !== es || s1_cout !== ec) begin
      errors++; $display("FAIL %s result: dv=%b sum=%b cout=%b want dv=1 sum=%b cout=%b",
                         tag, s1_dv, s1_sum, s1_cout, es, ec);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (s1_ovf !== eo) begin errors++; $display("FAIL %s ovf: got %b want %b", tag, s1_ovf, eo); end
`else
    if (eo === 1'bx) $display("note: %s ovf expectation unknown", tag);
`endif
    s1_dr = 1'b1;
    @(negedge clk);
    s1_dr = 1'b0;
    checks++;
    if (s1_dv !== 1'b0 || s1_sr !== 1'b1) begin
      errors++; $display("FAIL %s take: dv=%b ready=%b want dv=0 ready=1", tag, s1_dv, s1_sr);
    end
    $display("op1 %s: a=%b b=%b cin=%b -> sum=%b cout=%b", tag, ta, tb, tc, s1_sum, s1_cout);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (s8_sr !== 1'b1 || s8_dv !== 1'b0 || s8_busy !== 1'b0 || s8_sum !== 8'h00 || s8_cout !== 1'b0) begin
      errors++; $display("FAIL reset8: ready=%b dv=%b busy=%b sum=%h cout=%b want 1 0 0 00 0",
                         s8_sr, s8_dv, s8_busy, s8_sum, s8_cout);
    end
    checks++;
    if (s1_sr !== 1'b1 || s1_dv !== 1'b0 || s1_busy !== 1'b0 || s1_sum !== 1'b0 || s1_cout !== 1'b0) begin
      errors++; $display("FAIL reset1: ready=%b dv=%b busy=%b sum=%b cout=%b want 1 0 0 0 0",
                         s1_sr, s1_dv, s1_busy, s1_sum, s1_cout);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (s8_ovf !== 1'b0) begin errors++; $display("FAIL reset ovf: got %b want 0", s8_ovf); end
`endif
    @(negedge clk);
    rst = 1'b0;
    $display("reset: outputs checked with rst high before any clock edge");
  endtask

  task automatic test_w1_truth();
    logic [2:0] inp [8];
    logic [1:0] resp [8];
    int es; bit ec, eo;
    inp  = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
    resp = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      model(int'(inp[i][2]), int'(inp[i][1]), int'(inp[i][0]), 1, es, ec, eo);
      do_op1(inp[i][2], inp[i][1], inp[i][0], resp[i][1], resp[i][0], eo, $sformatf("w1_truth%0d", i));
    end
  endtask

  task automatic test_spec_vectors();
    do_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_plus_01");
    do_op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "7f_plus_01");
    do_op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "80_plus_80");
  endtask

  task automatic test_random();
    int ta, tb, tc, es;
    bit ec, eo;
    for (int i = 0; i < 16; i++) begin
      ta = int'($urandom_range(0, 255)); tb = int'($urandom_range(0, 255)); tc = int'($urandom_range(0, 1));
      model(ta, tb, tc, 8, es, ec, eo);
      do_op8(8'(ta), 8'(tb), 1'(tc), 8'(es), ec, eo, $sformatf("rand8_%0d", i));
    end
    for (int i = 0; i < 6; i++) begin
      ta = int'($urandom_range(0, 1)); tb = int'($urandom_range(0, 1)); tc = int'($urandom_range(0, 1));
      model(ta, tb, tc, 1, es, ec, eo);
      do_op1(1'(ta), 1'(tb), 1'(tc), 1'(es), ec, eo, $sformatf("rand1_%0d", i));
    end
  endtask

  task automatic test_reset_midrun();
    int es; bit ec, eo;
    @(negedge clk);
    s8_a = 8'hA5; s8_b = 8'h5A; s8_cin = 1'b1; s8_sv = 1'b1;
    @(negedge clk);
    s8_sv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (s8_sr !== 1'b1 || s8_dv !== 1'b0 || s8_busy !== 1'b0 || s8_sum !== 8'h00 || s8_cout !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: ready=%b dv=%b busy=%b sum=%h cout=%b want 1 0 0 00 0",
                         s8_sr, s8_dv, s8_busy, s8_sum, s8_cout);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (s8_ovf !== 1'b0) begin errors++; $display("FAIL midrun_reset ovf: got %b want 0", s8_ovf); end
`endif
    #1 rst = 1'b0;
    $display("midrun reset: asserted in third RUN cycle");
    model(32'h12, 32'h34, 1, 8, es, ec, eo);
    do_op8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, eo, "after_reset");
  endtask

  task automatic test_backpressure();
    int k, es, es2;
    bit ec, eo, ec2, eo2;
    logic [7:0] na, nb;
    model(32'h3C, 32'hD9, 0, 8, es, ec, eo);
    na = 8'($urandom_range(0, 255)); nb = 8'($urandom_range(0, 255));
    model(int'(na), int'(nb), 1, 8, es2, ec2, eo2);
    @(negedge clk);
    s8_a = 8'h3C; s8_b = 8'hD9; s8_cin = 1'b0; s8_sv = 1'b1;
    @(negedge clk);
    s8_sv = 1'b0;
    k = 0;
    while (s8_dv !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    checks++;
    if (k != 8) begin errors++; $display("FAIL bp latency: got %0d want 8", k); end
    for (int i = 0; i < 5; i++) begin
      s8_dr = 1'b0;
      s8_sv = (i == 1 || i == 2);
      s8_a = 8'($urandom_range(0, 255)); s8_b = 8'($urandom_range(0, 255)); s8_cin = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (s8_dv !== 1'b1 || s8_sr !== 1'b0 || s8_sum !== 8'(es) || s8_cout !== ec) begin
        errors++; $display("FAIL bp hold%0d: dv=%b ready=%b sum=%h cout=%b want dv=1 ready=0 sum=%h cout=%b",
                           i, s8_dv, s8_sr, s8_sum, s8_cout, 8'(es), ec);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++;
      if (s8_ovf !== eo) begin errors++; $display("FAIL bp ovf%0d: got %b want %b", i, s8_ovf, eo); end
`endif
    end
    // result taken with a request already waiting: it must not be accepted on that edge
    s8_dr = 1'b1; s8_sv = 1'b1; s8_a = na; s8_b = nb; s8_cin = 1'b1;
    @(negedge clk);
    s8_dr = 1'b0;
    checks++;
    if (s8_dv !== 1'b0 || s8_sr !== 1'b1 || s8_busy !== 1'b0 || s8_sum !== 8'(es)) begin
      errors++; $display("FAIL bp take: dv=%b ready=%b busy=%b sum=%h want 0 1 0 %h",
                         s8_dv, s8_sr, s8_busy, s8_sum, 8'(es));
    end
    @(negedge clk);
    s8_sv = 1'b0;
    checks++;
    if (s8_busy !== 1'b1) begin errors++; $display("FAIL bp next_accept: busy=%b want 1", s8_busy); end
    k = 0;
    while (s8_dv !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    checks++;
    if (k != 8 || s8_sum !== 8'(es2) || s8_cout !== ec2) begin
      errors++; $display("FAIL bp second: lat=%0d sum=%h cout=%b want lat=8 sum=%h cout=%b",
                         k, s8_sum, s8_cout, 8'(es2), ec2);
    end
    s8_dr = 1'b1;
    @(negedge clk);
    s8_dr = 1'b0;
    $display("backpressure: held 5 cycles, second op a=%h b=%h -> sum=%h", na, nb, s8_sum);
  endtask

  task automatic test_done_ready_idle();
    logic [7:0] held;
    held = s8_sum;
    s8_dr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    s8_dr = 1'b0;
    checks++;
    if (s8_dv !== 1'b0 || s8_sr !== 1'b1 || s8_busy !== 1'b0 || s8_sum !== held) begin
      errors++; $display("FAIL idle_done_ready: dv=%b ready=%b busy=%b sum=%h want 0 1 0 %h",
                         s8_dv, s8_sr, s8_busy, s8_sum, held);
    end
    $display("idle done_ready: ignored, sum held at %h", s8_sum);
  endtask

  initial begin
    s8_sv = 1'b0; s8_dr = 1'b0; s8_a = '0; s8_b = '0; s8_cin = 1'b0;
    s1_sv = 1'b0; s1_dr = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0;
    test_reset();
    test_w1_truth();
    test_spec_vectors();
    test_random();
    test_reset_midrun();
    test_backpressure();
    test_done_ready_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 1 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start_valid, input, 1 bit: an operation request is presented.
REQ-005 The block SHALL have port start_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A, sampled only at accept.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B, sampled only at accept.
REQ-008 The block SHALL have port c_in, input, 1 bit: carry into bit 0, sampled only at accept.
REQ-009 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-010 The block SHALL have port c_out, output, 1 bit: carry out of bit WIDTH-1.
REQ-011 The block SHALL have port done_valid, output, 1 bit: the result is valid.
REQ-012 The block SHALL have port done_ready, input, 1 bit: the consumer takes the result.
REQ-013 The block SHALL have port busy, output, 1 bit: high in RUN or DONE.
REQ-014 The block SHALL have port ovf, output, 1 bit: signed overflow; present only under the configuration macro.

Function
REQ-015 The block SHALL compute {c_out,sum} = a + b + c_in, one bit per clock, using one full-adder cell and one carry register.
REQ-016 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
- IDLE: start_ready=1.
- start_valid&&start_ready at an edge: capture a, b and c_in into shift and carry registers, clear the bit counter, go to RUN.
REQ-017 Each RUN edge SHALL perform the following, then leave RUN after exactly WIDTH edges.
- Add operand LSBs plus the carry register.
- Shift the sum bit into sum[WIDTH-1], shifting sum right.
- Shift the operands right and update the carry.
- Increment the counter; counter width is $clog2(WIDTH)+1.
REQ-018 On the final RUN edge the block SHALL go to DONE and load the final carry into c_out.
- DONE: done_valid=1.
- done_ready at an edge: go to IDLE.
REQ-019 Latency SHALL be as follows.
- done_valid rises exactly WIDTH cycles after the accept edge.
- Minimum accept-to-accept period is WIDTH+2 cycles.
- No new request is accepted in the cycle the result is taken.
REQ-020 start_ready SHALL be 0 in RUN and DONE; start_valid there SHALL be ignored and not queued.
REQ-021 done_ready while done_valid=0 SHALL be ignored.
REQ-022 In DONE, sum and c_out (and ovf if present) SHALL be stable regardless of a, b, c_in, start_valid or done_ready backpressure duration.
REQ-023 sum and c_out SHALL be defined only while done_valid=1; they SHALL hold their last result through IDLE until the next accept; partial values during RUN are don't-care.
REQ-024 WIDTH=1 SHALL behave as a registered one-bit full adder with done_valid one cycle after accept.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for a clock edge, force the FSM to IDLE and clear all state.
- Registers cleared: operands, counter, carry, sum, c_out, ovf.
- Resulting outputs: start_ready=1, done_valid=0, busy=0, sum=0, c_out=0, ovf=0.
REQ-026 Reset during RUN or DONE SHALL discard the operation; the first request after rst falls SHALL be accepted normally.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN SHALL control the signed-overflow feature.
- Defined: port ovf exists; on the final RUN edge it is loaded with (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1); it holds with sum.
- Undefined: port ovf and its register are absent; all other behaviour is unchanged.

Verification
REQ-028 The bench SHALL run WIDTH=1, all eight (a,b,c_in) combinations.
- Response: sum/c_out are 00,10,10,01,10,01,01,11 for inputs 000,100,010,110,001,101,011,111.
- done_valid follows 1 cycle after each accept.
REQ-029 The bench SHALL run WIDTH=8, a=8'hFF, b=8'h01, c_in=0.
- Response after 8 cycles: sum=8'h00, c_out=1, ovf=0.
REQ-030 The bench SHALL run WIDTH=8 with macro defined, a=8'h7F, b=8'h01, c_in=0.
- Response: sum=8'h80, c_out=0, ovf=1.
- Then a=8'h80, b=8'h80: sum=8'h00, c_out=1, ovf=1.
REQ-031 The bench SHALL run WIDTH=8, a=8'hA5, b=8'h5A, c_in=1, asserting rst during the 3rd RUN cycle.
- Response: outputs 0 and start_ready=1 without a clock edge.
- Then a=8'h12, b=8'h34, c_in=1: sum=8'h47, c_out=0.
REQ-032 The bench SHALL run WIDTH=8 with done_ready held 0 for 5 cycles in DONE, start_valid pulsed with new operands.
- Response: done_valid, sum and c_out stable, start_ready=0, request not taken.
- After done_ready=1: IDLE next cycle.
